// File: rtl/sum_tree_pkg.sv
// Shared types and helpers for the summing-tree environment.
// The entry struct uses the default widths so benches and models can share it.
package sum_tree_pkg;

    localparam int OVF_CNT_WIDTH  = 16;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_INPUTS = 8;
    localparam int DEF_SEQ_WIDTH  = 8;

    function automatic int sum_width(input int data_w, input int n);
        return data_w + $clog2(n);
    endfunction

    localparam int DEF_SUM_WIDTH = sum_width(DEF_DATA_WIDTH, DEF_NUM_INPUTS);

    typedef struct packed {
        logic [DEF_SEQ_WIDTH-1:0]  seq;
        logic [DEF_SUM_WIDTH-1:0]  sum;
        logic [DEF_DATA_WIDTH-1:0] mean;
    } result_entry_t;

endpackage

// File: rtl/sum_result_fifo.sv
// Generic first-word-fall-through FIFO with register storage.
// A push while full is taken only when a pop happens in the same cycle.
module sum_result_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/sum_result_collector.sv
// Captures every completed sum from the summing tree, tags it with a sequence
// number and rounded mean, and serves it over a valid/ready interface.
module sum_result_collector
    import sum_tree_pkg::*;
#(
    parameter  int NUM_INPUTS = 8,
    parameter  int DATA_WIDTH = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int SEQ_WIDTH  = 8,
    localparam int SUM_WIDTH  = sum_width(DATA_WIDTH, NUM_INPUTS),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SUM_WIDTH-1:0]     sum_in,
    input  logic                     sum_valid_in,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [SUM_WIDTH-1:0]     m_sum,
    output logic [DATA_WIDTH-1:0]    m_mean,
    output logic [SEQ_WIDTH-1:0]     m_seq,
    output logic [CNT_W-1:0]         fifo_count,
    output logic                     drop_pulse,
    output logic [OVF_CNT_WIDTH-1:0] overflow_cnt
);

    localparam int LOG2_N  = $clog2(NUM_INPUTS);
    localparam int ENTRY_W = SEQ_WIDTH + SUM_WIDTH + DATA_WIDTH;

    logic [DATA_WIDTH-1:0] mean;
    logic [SEQ_WIDTH-1:0]  seq_cnt;
    logic [ENTRY_W-1:0]    wr_entry;
    logic [ENTRY_W-1:0]    rd_entry;
    logic                  full;
    logic                  empty;
    logic                  pop;
    logic                  drop;

    // Round half up; the sum width leaves headroom so the add cannot carry out.
    assign mean     = DATA_WIDTH'((sum_in + SUM_WIDTH'(NUM_INPUTS / 2)) >> LOG2_N);
    assign wr_entry = {seq_cnt, sum_in, mean};

    assign m_valid = !empty;
    assign pop     = m_valid && m_ready;
    assign drop    = sum_valid_in && full && !pop;
    assign {m_seq, m_sum, m_mean} = rd_entry;

    sum_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (sum_valid_in),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    // Sequence advances on every pulse, so dropped results leave gaps in m_seq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt      <= '0;
            drop_pulse   <= 1'b0;
            overflow_cnt <= '0;
        end else begin
            if (sum_valid_in) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            drop_pulse <= drop;
            if (drop && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_count <= CNT_W'(FIFO_DEPTH));
    a_head_stable: assert property (@(posedge clk) disable iff (!rst_n)
        m_valid && !m_ready |=> m_valid && $stable({m_seq, m_sum, m_mean}));
`endif

endmodule
